// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter slice: FSM state
// encoding, transfer size codes, grant vector bit positions and the
// size coercion rule applied to load/store requests.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    localparam int GRANT_IF = 0;
    localparam int GRANT_LS = 1;

    // Only byte and half requests keep their size; anything else is a word.
    function automatic logic [2:0] coerce_size(input logic [2:0] size);
        case (size)
            SIZE_BYTE: return SIZE_BYTE;
            SIZE_HALF: return SIZE_HALF;
            default:   return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory arbiter. Purely combinational: the LSU
// wins by default, the fetch port wins when it alone is eligible or when
// the starvation counter has reached its limit while both are waiting.
// A squashed (flushed) fetch is never eligible.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_valid,
    input  logic             if_flush,
    input  logic             ls_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       grant
);

    logic if_eligible;
    logic guard_fire;

    // Priority decision: guard override, then LSU, then fetch.
    always_comb begin
        grant       = '0;
        if_eligible = if_valid && !if_flush;
        guard_fire  = if_eligible && ls_valid && (starve_cnt == CNT_W'(STARVE_MAX));
        if (guard_fire) begin
            grant[GRANT_IF] = 1'b1;
        end else if (ls_valid) begin
            grant[GRANT_LS] = 1'b1;
        end else if (if_eligible) begin
            grant[GRANT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Transaction-level arbiter between instruction fetch and the load/store
// unit in front of the byte-serial RAM engine. One request is in flight at
// a time; its completion is routed back to the requester, and a fetch that
// is flushed while in flight is drained and discarded.
// Optional feature: define IF_STARVE_GUARD_EN to add a saturating counter
// that forces a fetch grant after STARVE_MAX consecutive LSU grants taken
// while the fetch port was waiting. Without it the LSU has strict priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              ls_req_valid,
    input  logic              ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [2:0]        ls_req_size,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_data,
    output logic              dn_start,
    output logic              dn_we,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [2:0]        dn_size,
    output logic [DATA_W-1:0] dn_wdata,
    input  logic              dn_done,
    input  logic [DATA_W-1:0] dn_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [1:0]       pick_grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             if_done;
    logic             ls_done;
    logic [DATA_W-1:0] size_mask;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_valid   (if_req_valid),
        .if_flush   (if_flush),
        .ls_valid   (ls_req_valid),
        .starve_cnt (starve_cnt),
        .grant      (pick_grant)
    );

    // Next-state and handshake decode; nothing moves while rdy is low.
    always_comb begin
        state_next   = state;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if_done      = 1'b0;
        ls_done      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (rdy && !rst) begin
                    if_req_ready = pick_grant[GRANT_IF];
                    ls_req_ready = pick_grant[GRANT_LS];
                    if (pick_grant[GRANT_LS]) begin
                        state_next = ARB_BUSY_LS;
                    end else if (pick_grant[GRANT_IF]) begin
                        state_next = ARB_BUSY_IF;
                    end
                end
            end
            ARB_BUSY_IF: begin
                if (rdy) begin
                    if (dn_done) begin
                        if_done    = !if_flush;
                        state_next = ARB_IDLE;
                    end else if (if_flush) begin
                        state_next = ARB_DRAIN;
                    end
                end
            end
            ARB_BUSY_LS: begin
                if (rdy && dn_done) begin
                    ls_done    = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (rdy && dn_done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Byte-lane mask for load data, from the captured transfer size.
    always_comb begin
        size_mask = '1;
        case (dn_size)
            SIZE_BYTE: size_mask = DATA_W'(8'hFF);
            SIZE_HALF: size_mask = DATA_W'(16'hFFFF);
            default:   size_mask = '1;
        endcase
    end

    // Engine command capture, dn_start pulse and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_start      <= 1'b0;
            dn_we         <= 1'b0;
            dn_addr       <= '0;
            dn_size       <= '0;
            dn_wdata      <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
        end else if (rdy) begin
            dn_start      <= 1'b0;
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            if (ls_req_ready) begin
                dn_start <= 1'b1;
                dn_we    <= ls_req_we;
                dn_addr  <= ls_req_addr;
                dn_size  <= coerce_size(ls_req_size);
                dn_wdata <= ls_req_wdata;
            end else if (if_req_ready) begin
                dn_start <= 1'b1;
                dn_we    <= 1'b0;
                dn_addr  <= if_req_addr;
                dn_size  <= SIZE_WORD;
                dn_wdata <= '0;
            end
            if (if_done) begin
                if_resp_valid <= 1'b1;
                if_resp_data  <= dn_rdata;
            end
            if (ls_done) begin
                ls_resp_valid <= 1'b1;
                ls_resp_data  <= dn_we ? '0 : (dn_rdata & size_mask);
            end
        end
    end

`ifdef IF_STARVE_GUARD_EN
    // Starvation counter: counts LSU grants taken over a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rdy) begin
            if (!if_req_valid || if_req_ready) begin
                starve_cnt <= '0;
            end else if (ls_req_ready && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (one outstanding request record plus a streak count) predicts readies and
// registered outputs every cycle; a small engine model answers requests.
// Directed scenarios are followed by a randomized run.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rdy = 1'b1;
    logic              if_req_valid = 1'b0;
    logic [ADDR_W-1:0] if_req_addr = '0;
    logic              if_req_ready;
    logic              if_flush = 1'b0;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              ls_req_valid = 1'b0;
    logic              ls_req_we = 1'b0;
    logic [ADDR_W-1:0] ls_req_addr = '0;
    logic [2:0]        ls_req_size = 3'd0;
    logic [DATA_W-1:0] ls_req_wdata = '0;
    logic              ls_req_ready;
    logic              ls_resp_valid;
    logic [DATA_W-1:0] ls_resp_data;
    logic              dn_start;
    logic              dn_we;
    logic [ADDR_W-1:0] dn_addr;
    logic [2:0]        dn_size;
    logic [DATA_W-1:0] dn_wdata;
    logic              dn_done = 1'b0;
    logic [DATA_W-1:0] dn_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_flush      (if_flush),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_we     (ls_req_we),
        .ls_req_addr   (ls_req_addr),
        .ls_req_size   (ls_req_size),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .dn_start      (dn_start),
        .dn_we         (dn_we),
        .dn_addr       (dn_addr),
        .dn_size       (dn_size),
        .dn_wdata      (dn_wdata),
        .dn_done       (dn_done),
        .dn_rdata      (dn_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the one request in flight, described as a record.
    bit          m_busy = 0;
    bit          m_for_ls = 0;
    bit          m_squashed = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    int          m_size = 0;
    logic [31:0] m_wdata = '0;
    int          m_streak = 0;
    bit          e_start = 0;
    bit          e_if_rv = 0;
    bit          e_ls_rv = 0;
    logic [31:0] e_if_rd = '0;
    logic [31:0] e_ls_rd = '0;

    // Engine model and knobs for the next transaction.
    bit          eng_busy = 0;
    int          eng_wait = 0;
    logic [31:0] eng_rdata = '0;
    int          next_lat = 2;
    logic [31:0] next_rdata = '0;

    bit          obs_if_ready = 0;
    bit          obs_ls_ready = 0;
    bit          last_done = 0;

    // Count one comparison and report it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int sizeBytes(input logic [2:0] code);
        if (code == 3'd1) return 1;
        if (code == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] sizeMask(input int n);
        if (n >= 4) return 32'hFFFF_FFFF;
        return 32'((64'd1 << (8 * n)) - 64'd1);
    endfunction

    // Which requester should see ready with the inputs currently driven.
    task automatic expectReady(output bit eif, output bit els);
        bit ifOk;
        bit starved;
        ifOk = if_req_valid && !if_flush;
`ifdef IF_STARVE_GUARD_EN
        starved = (m_streak >= STARVE_MAX);
`else
        starved = 0;
`endif
        eif = 0;
        els = 0;
        if (!m_busy && rdy && !rst) begin
            if (starved && ifOk && ls_req_valid) eif = 1;
            else if (ls_req_valid) els = 1;
            else if (ifOk) eif = 1;
        end
    endtask

    // Advance the model across one clock edge.
    task automatic modelEdge(input bit eif, input bit els);
        if (rst) begin
            m_busy = 0; m_squashed = 0; m_we = 0; m_addr = '0; m_size = 0; m_wdata = '0;
            m_streak = 0; e_start = 0; e_if_rv = 0; e_ls_rv = 0; e_if_rd = '0; e_ls_rd = '0;
            eng_busy = 0;
            return;
        end
        if (!rdy) return;
        e_start = 0;
        e_if_rv = 0;
        e_ls_rv = 0;
        if (m_busy) begin
            if (dn_done) begin
                if (m_for_ls) begin
                    e_ls_rv = 1;
                    e_ls_rd = m_we ? 32'd0 : (dn_rdata & sizeMask(m_size));
                end else if (!m_squashed && !if_flush) begin
                    e_if_rv = 1;
                    e_if_rd = dn_rdata;
                end
                m_busy = 0;
                eng_busy = 0;
            end else begin
                if (!m_for_ls && if_flush) m_squashed = 1;
                if (eng_wait > 0) eng_wait--;
            end
        end else if (eif || els) begin
            m_busy = 1;
            m_for_ls = els;
            m_squashed = 0;
            e_start = 1;
            if (els) begin
                m_we = ls_req_we; m_addr = ls_req_addr; m_size = sizeBytes(ls_req_size); m_wdata = ls_req_wdata;
            end else begin
                m_we = 0; m_addr = if_req_addr; m_size = 4;
            end
            eng_busy = 1;
            eng_wait = next_lat;
            eng_rdata = next_rdata;
        end
        if (!if_req_valid || eif) m_streak = 0;
        else if (els && m_streak < STARVE_MAX) m_streak++;
    endtask

    // Compare registered outputs against the model after an edge.
    task automatic checkRegs();
        checkOutput("dn_start", dn_start, e_start);
        checkOutput("if_resp_valid", if_resp_valid, e_if_rv);
        checkOutput("ls_resp_valid", ls_resp_valid, e_ls_rv);
        if (e_if_rv) checkOutput("if_resp_data", if_resp_data, e_if_rd);
        if (e_ls_rv) checkOutput("ls_resp_data", ls_resp_data, e_ls_rd);
        checkOutput("dn_we", dn_we, m_we);
        checkOutput("dn_addr", dn_addr, m_addr);
        checkOutput("dn_size", dn_size, 32'(m_size));
        if (m_we) checkOutput("dn_wdata", dn_wdata, m_wdata);
    endtask

    // One clock cycle: drive at negedge, check readies, clock, check registers.
    task automatic applyStimulus(input bit i_rst, input bit i_rdy, input bit ifv, input logic [31:0] ifa,
                                 input bit fl, input bit lsv, input bit we, input logic [31:0] lsa,
                                 input logic [2:0] sz, input logic [31:0] wd);
        bit eif;
        bit els;
        @(negedge clk);
        rst = i_rst; rdy = i_rdy;
        if_req_valid = ifv; if_req_addr = ifa; if_flush = fl;
        ls_req_valid = lsv; ls_req_we = we; ls_req_addr = lsa; ls_req_size = sz; ls_req_wdata = wd;
        dn_done = eng_busy && (eng_wait == 0);
        dn_rdata = eng_rdata;
        last_done = dn_done && i_rdy && !i_rst;
        expectReady(eif, els);
        #1;
        obs_if_ready = if_req_ready;
        obs_ls_ready = ls_req_ready;
        if (!i_rst) begin
            checkOutput("if_req_ready", if_req_ready, 32'(eif));
            checkOutput("ls_req_ready", ls_req_ready, 32'(els));
        end
        @(posedge clk);
        modelEdge(eif, els);
        #1;
        checkRegs();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    endtask

    // Step until the selected response pulses, optionally checking its data.
    task automatic waitResp(input string tag, input bit forLs, input bit holdIf, input logic [31:0] ifa,
                            input bit checkData, input logic [31:0] expData);
        bit seen;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, holdIf, ifa, 0, 0, 0, 0, 3'd0, 0);
            if (forLs ? ls_resp_valid : if_resp_valid) begin
                seen = 1;
                if (checkData) checkOutput(tag, forLs ? ls_resp_data : if_resp_data, expData);
                break;
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 1);
    endtask

    initial begin
        int ifGrants;
        int lsGrants;
        int ifPulses;
        bit doneSeen;
        bit prevDone;

        // Reset state.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        checkOutput("rst_dn_start", dn_start, 0);
        checkOutput("rst_dn_addr", dn_addr, 0);
        checkOutput("rst_ls_resp_data", ls_resp_data, 0);
        checkOutput("rst_if_resp_data", if_resp_data, 0);
        idleCycle();

        // Collision: LSU wins, fetch granted once the load completes.
        next_lat = 3; next_rdata = 32'hDEAD_BEEF;
        applyStimulus(0, 1, 1, 32'h100, 0, 1, 0, 32'h2000, 3'd4, 0);
        checkOutput("collide_ls_ready", 32'(obs_ls_ready), 1);
        checkOutput("collide_if_ready", 32'(obs_if_ready), 0);
        waitResp("collide_data", 1, 1, 32'h100, 1, 32'hDEAD_BEEF);
        checkOutput("collide_if_grant", if_req_ready, 1);
        next_lat = 2; next_rdata = 32'h0000_0013;
        applyStimulus(0, 1, 1, 32'h100, 0, 0, 0, 0, 3'd0, 0);
        waitResp("fetch_data", 0, 0, 0, 1, 32'h0000_0013);

        // Half-word load masking.
        next_lat = 2; next_rdata = 32'h1234_5678;
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h10, 3'd2, 0);
        waitResp("half_data", 1, 0, 0, 1, 32'h0000_5678);

        // Byte store: captured fields, then a zero-data completion.
        next_lat = 2; next_rdata = 32'hFFFF_FFFF;
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 32'h30000, 3'd1, 32'hAB);
        checkOutput("store_dn_we", dn_we, 1);
        checkOutput("store_dn_size", dn_size, 1);
        checkOutput("store_dn_wdata", dn_wdata, 32'hAB);
        waitResp("store_data", 1, 0, 0, 1, 32'h0);

        // Flush two cycles after a fetch grant: discarded, idle right after done.
        next_lat = 4; next_rdata = 32'hCAFE_0001;
        applyStimulus(0, 1, 1, 32'h400, 0, 0, 0, 0, 3'd0, 0);
        idleCycle();
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 3'd0, 0);
        ifPulses = 0; doneSeen = 0;
        next_lat = 1; next_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 12; i++) begin
            prevDone = last_done;
            applyStimulus(0, 1, 1, 32'h404, 0, 0, 0, 0, 3'd0, 0);
            if (prevDone) begin
                checkOutput("flush_idle_after_done", 32'(obs_if_ready), 1);
                doneSeen = 1;
                break;
            end
            if (if_resp_valid) ifPulses++;
        end
        checkOutput("flush_done_seen", 32'(doneSeen), 1);
        checkOutput("flush_no_resp", 32'(ifPulses), 0);
        waitResp("refetch_data", 0, 0, 0, 1, 32'h0BAD_F00D);

        // Reset during a load: abandoned, idle on the next cycle.
        next_lat = 4; next_rdata = 32'h5555_AAAA;
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h80, 3'd4, 0);
        idleCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        next_lat = 1; next_rdata = 32'h0000_00C3;
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h84, 3'd1, 0);
        checkOutput("rst_mid_idle", 32'(obs_ls_ready), 1);
        waitResp("post_rst_data", 1, 0, 0, 1, 32'h0000_00C3);

        // rdy low for three cycles right after a grant: everything holds.
        next_lat = 1; next_rdata = 32'h7777_8888;
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h90, 3'd4, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'h200, 0, 1, 0, 32'h94, 3'd4, 0);
        checkOutput("rdy_hold_start", dn_start, 1);
        waitResp("rdy_data", 1, 0, 0, 1, 32'h7777_8888);

        // Both requesters held valid.
        idleCycle();
        ifGrants = 0; lsGrants = 0;
`ifdef IF_STARVE_GUARD_EN
        for (int round = 0; round < 2; round++) begin
            lsGrants = 0; ifGrants = 0;
            for (int i = 0; i < 40 && ifGrants == 0; i++) begin
                next_lat = 1; next_rdata = $urandom;
                applyStimulus(0, 1, 1, 32'h300, 0, 1, 0, 32'h3000, 3'd4, 0);
                if (obs_ls_ready) lsGrants++;
                if (obs_if_ready) ifGrants++;
            end
            checkOutput("starve_ls_grants", 32'(lsGrants), STARVE_MAX);
            checkOutput("starve_if_grant", 32'(ifGrants), 1);
        end
`else
        for (int i = 0; i < 30; i++) begin
            next_lat = 1; next_rdata = $urandom;
            applyStimulus(0, 1, 1, 32'h300, 0, 1, 0, 32'h3000, 3'd4, 0);
            if (obs_ls_ready) lsGrants++;
            if (obs_if_ready) ifGrants++;
        end
        checkOutput("strict_if_grants", 32'(ifGrants), 0);
        checkOutput("strict_ls_grants", 32'(lsGrants > 0), 1);
`endif
        for (int i = 0; i < 4; i++) idleCycle();

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            next_lat = $urandom_range(1, 4);
            next_rdata = $urandom;
            applyStimulus(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 4) != 0),
                          1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 6) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          3'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Transaction-level arbiter between the instruction-fetch port and the load/store unit, in front of the byte-serial RAM engine.
- Accepts whole-word/half/byte requests from both requesters over valid/ready handshakes and grants one at a time to the engine.
- Routes each completion back to its originator, discarding fetches that a branch has squashed.
- Priority is LSU over IF, with an optional starvation guard for IF.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive LSU grants tolerated while IF waits (guard only)
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high; dominates rdy
- rdy  in  1  global enable; when low, state, counters and registered outputs hold
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch accepted this cycle (combinational)
- if_flush  in  1  jump/branch; squash pending fetch
- if_resp_valid  out  1  one-cycle pulse, instruction valid
- if_resp_data  out  DATA_W  instruction word
- ls_req_valid  in  1  load/store request
- ls_req_we  in  1  1 = store
- ls_req_addr  in  ADDR_W  byte address
- ls_req_size  in  3  bytes: 1, 2 or 4
- ls_req_wdata  in  DATA_W  store data, LSB-aligned
- ls_req_ready  out  1  LSU request accepted (combinational)
- ls_resp_valid  out  1  one-cycle pulse, load data valid / store complete
- ls_resp_data  out  DATA_W  load data, zero-extended; 0 for stores
- dn_start  out  1  one-cycle pulse launching an engine transaction
- dn_we, dn_addr, dn_size, dn_wdata  out  1/ADDR_W/3/DATA_W  captured request fields; held from dn_start until dn_done
- dn_done  in  1  engine completion pulse; sampled only when rdy=1
- dn_rdata  in  DATA_W  engine read data, valid with dn_done

## Operation
- States: IDLE, BUSY_IF, BUSY_LS, DRAIN.
- IDLE grant, taken when rdy=1:
  - LSU if ls_req_valid.
  - Otherwise IF if if_req_valid && !if_flush.
  - The granted ready is high; the other ready is low.
  - Fields are captured and the state moves to BUSY_IF or BUSY_LS.
- BUSY_*: both readies are 0. On dn_done:
  - Register the response.
  - Pulse the matching *_resp_valid.
  - Return to IDLE.
- BUSY_IF with if_flush=1 moves to DRAIN. DRAIN waits for dn_done, discards the data (no if_resp_valid), then returns to IDLE.
- if_flush during DRAIN or BUSY_LS has no effect.
- Size handling:
  - ls_req_size values other than 1/2 are coerced to 4.
  - Load data is masked to size bytes; upper bytes are 0.
  - IF is always size 4, we=0.
- Reset values:
  - State IDLE.
  - All *_valid, dn_start and dn_we are 0.
  - Data, address and size registers are 0.
  - Starvation counter is 0.
- rst mid-transaction abandons it without any response; the engine is reset by the same rst.

## Timing
- Cycle T: valid && ready → accept at edge. dn_start=1 in T+1 only.
- dn_done in cycle D ≥ T+2 → resp_valid=1 and resp_data stable in D+1. The state is IDLE in D+1, and a new grant is possible in D+1.
- Back-to-back throughput: one grant per engine completion plus one cycle.
- if_flush in the same cycle as dn_done in BUSY_IF: the fetch is discarded and the state goes to IDLE.
- Simultaneous if_req_valid and ls_req_valid in IDLE: LSU wins, unless the guard fires.
- rdy low: readies are forced to 0 and no transitions occur. A pending dn_start pulse is extended until the first rdy=1 cycle.

## Configuration
- IF_STARVE_GUARD_EN defined:
  - A saturating counter increments on each LSU grant made while if_req_valid=1.
  - It clears on an IF grant or whenever if_req_valid=0.
  - When counter == STARVE_MAX and both requesters are valid, IF is granted.
- Undefined: no counter; strict LSU priority.

## Structure
- State encodings (`ARB_IDLE`, `ARB_BUSY_IF`, `ARB_BUSY_LS`, `ARB_DRAIN`) and size codes go in config.v alongside the existing state macros.
- One combinational sub-module, mem_arb_pick, takes the valids, flush and counter and produces the grant vector.

## Test plan
- LSU-IF collision:
  - Stimulus: in IDLE, if_req_valid=1 addr 0x100 and ls_req_valid=1 load size 4 addr 0x2000; engine done after 4 cycles with rdata 0xDEADBEEF.
  - Required: ls_resp_data=0xDEADBEEF. The IF request is granted in the cycle after the response.
- Half-word masking:
  - Stimulus: load size 2 at 0x10 with dn_rdata=0x12345678.
  - Required: ls_resp_data=0x00005678.
- Store completion:
  - Stimulus: store size 1, wdata 0xAB, addr 0x30000.
  - Required: dn_we=1, dn_size=1, dn_wdata=0xAB. On dn_done, ls_resp_valid pulses with data 0.
- Flush mid-fetch:
  - Stimulus: if_flush asserted 2 cycles after an IF grant.
  - Required: no if_resp_valid. The state is IDLE the cycle after dn_done.
- Starvation guard:
  - Stimulus: with IF_STARVE_GUARD_EN and STARVE_MAX=4, both requesters held valid.
  - Required: 4 LSU grants, then an IF grant, then the counter is 0.
- Reset and rdy:
  - Stimulus: rst pulsed during BUSY_LS.
  - Required: next cycle IDLE, no ls_resp_valid. With rdy=0 for 3 cycles, all state holds.
